mem_arbiter_rr: RTL and testbench

- N-channel arbiter that shares one line-wide memory port among several cache-side requesters (icache, dcache, future DMA and prefetcher).
- Successor to the fixed two-port icache/dcache arbiter, parametrised in:
  - channel count;
  - address width;
  - line width;
  - arbitration mode: fixed priority or round-robin.
- Holds a grant for a whole transaction.
- Sits between the per-channel cache memory ports and the single memory model.

---
 rtl/mem_arbiter_rr.sv | 138 +++++++++++++
 tb/tb_mem_arbiter_rr.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
// Shares one line-wide memory port among NUM_CHANNELS cache-side requesters.
// A winner is picked in IDLE, by lowest index or round-robin from r_rr_ptr.
// That grant is held for the whole transaction and released on mem_ready_i.
//
// Handshake: a requester raises ch_valid_i[k] and holds write/addr/wdata
// stable until ch_ready_o[k] pulses for one cycle. On the next cycle it drops
// or renews valid. The memory side sees mem_valid_o held high for the whole
// BUSY period and answers with a one-cycle mem_ready_i pulse; that pulse is
// the completion. mem_ready_i is ignored outside BUSY.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   ch_valid_i/ch_write_i     per-channel request valid / write flag
//   ch_addr_i/ch_wdata_i      per-channel packed address / write line
//   ch_ready_o/ch_rdata_o     completion pulse (one-hot) / read line
//   mem_valid_o..mem_wdata_o  request to the memory model
//   mem_rdata_i/mem_ready_i   response from the memory model
//   grant_o, busy_o           debug view of the FSM (grant index, BUSY state)
module mem_arbiter_rr #(
    parameter int NUM_CHANNELS = 2,
    parameter int ADDR_SIZE    = 32,
    parameter int LINE_SIZE    = 256,
    parameter int RR_MODE      = 1,
    parameter int GW           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [NUM_CHANNELS-1:0]           ch_valid_i,
    input  logic [NUM_CHANNELS-1:0]           ch_write_i,
    input  logic [NUM_CHANNELS*ADDR_SIZE-1:0] ch_addr_i,
    input  logic [NUM_CHANNELS*LINE_SIZE-1:0] ch_wdata_i,
    output logic [NUM_CHANNELS-1:0]           ch_ready_o,
    output logic [LINE_SIZE-1:0]              ch_rdata_o,
    output logic                              mem_valid_o,
    output logic                              mem_write_o,
    output logic [ADDR_SIZE-1:0]              mem_addr_o,
    output logic [LINE_SIZE-1:0]              mem_wdata_o,
    input  logic [LINE_SIZE-1:0]              mem_rdata_i,
    input  logic                              mem_ready_i,
    output logic [GW-1:0]                     grant_o,
    output logic                              busy_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_rr_ptr;

    logic [GW-1:0]   w_start;
    logic [GW-1:0]   w_win;
    logic            w_hit;
    logic            w_any;
    logic            w_busy;
    logic            w_done;

    assign w_any  = |ch_valid_i;
    assign w_busy = (r_state == ST_BUSY);
    assign w_done = w_busy && mem_ready_i;

    // Fixed mode always scans from 0; round-robin scans from the pointer.
    assign w_start = (RR_MODE != 0) ? r_rr_ptr : '0;

    // Two-pass scan: first the set bits at or above w_start, then wrap around
    // to the lowest set bit. Avoids variable-index arithmetic on the vector.
    always_comb begin
        w_win = '0;
        w_hit = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!w_hit && ch_valid_i[i] && (GW'(i) >= w_start)) begin
                w_win = GW'(i);
                w_hit = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!w_hit && ch_valid_i[i]) begin
                w_win = GW'(i);
                w_hit = 1'b1;
            end
        end
    end

    // Memory request is muxed from the registered grant and forced to zero
    // outside BUSY, so a reset clears it without waiting for a clock edge.
    always_comb begin
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        ch_ready_o  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_busy && (r_grant == GW'(i))) begin
                mem_write_o = ch_write_i[i];
                mem_addr_o  = ch_addr_i[i*ADDR_SIZE +: ADDR_SIZE];
                mem_wdata_o = ch_wdata_i[i*LINE_SIZE +: LINE_SIZE];
                ch_ready_o[i] = mem_ready_i;
            end
        end
    end

    assign ch_rdata_o  = w_done ? mem_rdata_i : '0;
    assign mem_valid_o = w_busy;
    assign busy_o      = w_busy;
    assign grant_o     = r_grant;

    // Completion always returns to IDLE, so a request still held during the
    // ready cycle is only looked at again one cycle later.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready_i) begin
                        r_state <= ST_IDLE;
                        if (RR_MODE != 0) begin
                            if (r_grant == GW'(NUM_CHANNELS - 1)) begin
                                r_rr_ptr <= '0;
                            end else begin
                                r_rr_ptr <= r_grant + 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with two instances.
//   u_fx: 2 channels, fixed priority.
//   u_rr: 4 channels, round-robin.
// Inputs are driven 1 time unit after the rising edge. Outputs are checked
// after a further settle delay, well away from the next edge.
module tb_mem_arbiter_rr;

    localparam int AW = 32;
    localparam int LW = 256;

    logic clk;
    logic rst;

    // 2-channel fixed-priority instance
    logic [1:0]      fx_valid, fx_write, fx_ready;
    logic [2*AW-1:0] fx_addr;
    logic [2*LW-1:0] fx_wdata;
    logic [LW-1:0]   fx_rdata, fx_mwdata, fx_mrdata;
    logic            fx_mvalid, fx_mwrite, fx_mready, fx_busy;
    logic [AW-1:0]   fx_maddr;
    logic [0:0]      fx_grant;

    // 4-channel round-robin instance
    logic [3:0]      rr_valid, rr_write, rr_ready;
    logic [4*AW-1:0] rr_addr;
    logic [4*LW-1:0] rr_wdata;
    logic [LW-1:0]   rr_rdata, rr_mwdata, rr_mrdata;
    logic            rr_mvalid, rr_mwrite, rr_mready, rr_busy;
    logic [AW-1:0]   rr_maddr;
    logic [1:0]      rr_grant;

    int checks = 0;
    int errors = 0;

    logic [LW-1:0] a5_line;
    logic [LW-1:0] beef_line;

    mem_arbiter_rr #(.NUM_CHANNELS(2), .ADDR_SIZE(AW), .LINE_SIZE(LW), .RR_MODE(0)) u_fx (
        .clk_i(clk), .reset_i(rst),
        .ch_valid_i(fx_valid), .ch_write_i(fx_write), .ch_addr_i(fx_addr),
        .ch_wdata_i(fx_wdata), .ch_ready_o(fx_ready), .ch_rdata_o(fx_rdata),
        .mem_valid_o(fx_mvalid), .mem_write_o(fx_mwrite), .mem_addr_o(fx_maddr),
        .mem_wdata_o(fx_mwdata), .mem_rdata_i(fx_mrdata), .mem_ready_i(fx_mready),
        .grant_o(fx_grant), .busy_o(fx_busy)
    );

    mem_arbiter_rr #(.NUM_CHANNELS(4), .ADDR_SIZE(AW), .LINE_SIZE(LW), .RR_MODE(1)) u_rr (
        .clk_i(clk), .reset_i(rst),
        .ch_valid_i(rr_valid), .ch_write_i(rr_write), .ch_addr_i(rr_addr),
        .ch_wdata_i(rr_wdata), .ch_ready_o(rr_ready), .ch_rdata_o(rr_rdata),
        .mem_valid_o(rr_mvalid), .mem_write_o(rr_mwrite), .mem_addr_o(rr_maddr),
        .mem_wdata_o(rr_mwdata), .mem_rdata_i(rr_mrdata), .mem_ready_i(rr_mready),
        .grant_o(rr_grant), .busy_o(rr_busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        a5_line   = {32{8'hA5}};
        beef_line = {8{32'hDEAD_BEEF}};
        rst = 1'b1;
        fx_valid = '0; fx_write = '0; fx_addr = '0; fx_wdata = '0;
        fx_mready = 1'b0; fx_mrdata = '0;
        rr_valid = '0; rr_write = '0; rr_addr = '0; rr_wdata = '0;
        rr_mready = 1'b0; rr_mrdata = '0;
        #2;
        chk("rst_fx_mvalid", LW'(fx_mvalid), '0);
        chk("rst_fx_busy",   LW'(fx_busy),   '0);
        chk("rst_fx_grant",  LW'(fx_grant),  '0);
        chk("rst_fx_maddr",  LW'(fx_maddr),  '0);
        chk("rst_rr_ready",  LW'(rr_ready),  '0);
        chk("rst_rr_rdata",  rr_rdata,       '0);
        chk("rst_rr_mwrite", LW'(rr_mwrite), '0);
        chk("rst_rr_mwdata", rr_mwdata,      '0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // mem_ready_i while idle must be ignored
        fx_mready = 1'b1; fx_mrdata = a5_line;
        settle();
        chk("idle_rdy_ready", LW'(fx_ready), '0);
        chk("idle_rdy_rdata", fx_rdata,      '0);
        tick();
        fx_mready = 1'b0; fx_mrdata = '0;
        chk("idle_rdy_busy",  LW'(fx_busy),  '0);

        // Single read on ch1, memory delay 5
        fx_valid = 2'b10; fx_addr[AW +: AW] = 32'h100;
        settle();
        chk("rd_pre_mvalid", LW'(fx_mvalid), '0);
        tick();
        chk("rd_mvalid", LW'(fx_mvalid), 1);
        chk("rd_maddr",  LW'(fx_maddr),  32'h100);
        chk("rd_mwrite", LW'(fx_mwrite), '0);
        chk("rd_grant",  LW'(fx_grant),  1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rd_wait_mvalid", LW'(fx_mvalid), 1);
            chk("rd_wait_ready",  LW'(fx_ready),  '0);
        end
        tick();
        fx_mready = 1'b1; fx_mrdata = a5_line;
        settle();
        chk("rd_ready", LW'(fx_ready), 2'b10);
        chk("rd_rdata", fx_rdata,      a5_line);
        tick();
        fx_mready = 1'b0; fx_mrdata = '0; fx_valid = 2'b00;
        settle();
        chk("rd_after_busy",  LW'(fx_busy),  '0);
        chk("rd_after_ready", LW'(fx_ready), '0);
        chk("rd_after_rdata", fx_rdata,      '0);
        chk("rd_after_grant", LW'(fx_grant), 1);
        tick();

        // Fixed priority: ch0 and ch1 together
        fx_valid = 2'b11; fx_addr = {32'h20, 32'h10};
        tick();
        chk("fp_grant0", LW'(fx_grant), 0);
        chk("fp_addr0",  LW'(fx_maddr), 32'h10);
        fx_mready = 1'b1;
        settle();
        chk("fp_ready0", LW'(fx_ready), 2'b01);
        tick();
        fx_mready = 1'b0; fx_valid = 2'b10;
        settle();
        chk("fp_gap_mvalid", LW'(fx_mvalid), '0);
        tick();
        chk("fp_grant1",  LW'(fx_grant),  1);
        chk("fp_mvalid1", LW'(fx_mvalid), 1);
        chk("fp_addr1",   LW'(fx_maddr),  32'h20);
        fx_mready = 1'b1;
        settle();
        chk("fp_ready1", LW'(fx_ready), 2'b10);
        tick();
        fx_mready = 1'b0; fx_valid = 2'b00;
        tick();

        // Grant stability: ch0 arrives while ch1 is being served
        fx_valid = 2'b10; fx_addr = {32'h300, 32'h40};
        tick();
        fx_valid = 2'b11;
        tick();
        chk("gs_grant_a", LW'(fx_grant), 1);
        tick();
        chk("gs_grant_b", LW'(fx_grant), 1);
        chk("gs_addr",    LW'(fx_maddr), 32'h300);
        fx_mready = 1'b1;
        settle();
        chk("gs_ready1", LW'(fx_ready), 2'b10);
        tick();
        fx_mready = 1'b0; fx_valid = 2'b01;
        settle();
        chk("gs_gap_busy", LW'(fx_busy), '0);
        tick();
        chk("gs_grant0", LW'(fx_grant), 0);
        chk("gs_addr0",  LW'(fx_maddr), 32'h40);
        fx_mready = 1'b1;
        settle();
        chk("gs_ready0", LW'(fx_ready), 2'b01);
        tick();
        fx_mready = 1'b0; fx_valid = 2'b00;
        tick();

        // Round-robin, all four channels requesting continuously
        rr_addr = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
        rr_valid = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk("rr_grant", LW'(rr_grant), LW'(t % 4));
            chk("rr_addr",  LW'(rr_maddr), LW'(32'h1000 + (t % 4)));
            rr_mready = 1'b1; rr_mrdata = LW'(t + 1);
            settle();
            chk("rr_ready", LW'(rr_ready), LW'(4'b0001 << (t % 4)));
            chk("rr_rdata", rr_rdata,      LW'(t + 1));
            tick();
            rr_mready = 1'b0; rr_mrdata = '0;
            settle();
            chk("rr_gap_busy", LW'(rr_busy), '0);
        end
        rr_valid = 4'b0000;
        tick();

        // Write passthrough on ch2 (pointer has wrapped back to 0)
        rr_valid = 4'b0100; rr_write = 4'b0100;
        rr_addr[2*AW +: AW] = 32'h2000;
        rr_wdata[2*LW +: LW] = beef_line;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("wr_mwrite", LW'(rr_mwrite), 1);
            chk("wr_mwdata", rr_mwdata,      beef_line);
            chk("wr_maddr",  LW'(rr_maddr),  32'h2000);
            tick();
        end
        rr_mready = 1'b1;
        settle();
        chk("wr_ready", LW'(rr_ready), 4'b0100);
        tick();
        rr_mready = 1'b0; rr_valid = 4'b0000; rr_write = 4'b0000;
        settle();
        chk("wr_after_mwrite", LW'(rr_mwrite), '0);
        tick();

        // Pointer is now 3: a lone ch1 request wraps to ch1, then reset mid-BUSY
        rr_valid = 4'b0010;
        fx_valid = 2'b10;
        tick();
        chk("rs_pre_grant", LW'(rr_grant), 1);
        chk("rs_pre_busy",  LW'(rr_busy),  1);
        chk("rs_pre_fxgnt", LW'(fx_grant), 1);
        #3;
        rst = 1'b1;
        settle();
        chk("rs_rr_mvalid", LW'(rr_mvalid), '0);
        chk("rs_rr_busy",   LW'(rr_busy),   '0);
        chk("rs_rr_grant",  LW'(rr_grant),  '0);
        chk("rs_fx_mvalid", LW'(fx_mvalid), '0);
        chk("rs_fx_grant",  LW'(fx_grant),  '0);
        rr_valid = 4'b0000; fx_valid = 2'b00;
        tick();
        rst = 1'b0;
        tick();

        // After reset: pointer back at 0, ch0 served normally
        rr_valid = 4'b1111;
        fx_valid = 2'b01; fx_addr[0 +: AW] = 32'h77;
        tick();
        chk("post_rr_grant", LW'(rr_grant), 0);
        chk("post_fx_grant", LW'(fx_grant), 0);
        chk("post_fx_addr",  LW'(fx_maddr), 32'h77);
        fx_mready = 1'b1; rr_mready = 1'b1; fx_mrdata = a5_line;
        settle();
        chk("post_fx_ready", LW'(fx_ready), 2'b01);
        chk("post_fx_rdata", fx_rdata,      a5_line);
        chk("post_rr_ready", LW'(rr_ready), 4'b0001);
        tick();
        fx_mready = 1'b0; rr_mready = 1'b0; fx_valid = 2'b00; rr_valid = 4'b0000;
        settle();
        chk("post_fx_idle", LW'(fx_busy), '0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
